// File: rtl/my_serial_adder.sv
// my_serial_adder: digit-serial adder/subtractor with start/busy/done handshake, carry-out and signed overflow
module my_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb, acc, nxt;
  logic [CW-1:0] cnt;
  logic carry, msb_cin;
  logic [DIGIT:0] d;
  // one digit step: low digits of both operand shift registers plus the running carry
  always_comb begin
    d = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + (DIGIT+1)'(carry);
    nxt = WIDTH'({d[DIGIT-1:0], acc} >> DIGIT);
    msb_cin = ra[DIGIT-1] ^ rb[DIGIT-1] ^ d[DIGIT-1];
  end
  // control FSM plus datapath registers; results load only on the final digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      c_out <= 1'b0;
      ovf <= 1'b0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      cnt <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            ra <= a;
            rb <= sub ? ~b : b;
            carry <= sub;
            cnt <= '0;
            busy <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          ra <= ra >> DIGIT;
          rb <= rb >> DIGIT;
          acc <= nxt;
          carry <= d[DIGIT];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum <= nxt;
            c_out <= d[DIGIT];
            ovf <= msb_cin ^ d[DIGIT];
            done <= 1'b1;
            busy <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_my_serial_adder.sv
// tb_my_serial_adder: checks three digit widths against an arithmetic model plus literal expectations
module tb_my_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0] busy, done, c_out, ovf;
  logic [31:0] sum [3];
  int compared = 0, mismatched = 0;
  int rem [3];
  logic [31:0] m_sum [3], p_sum [3];
  bit m_done [3], m_c [3], m_v [3], p_c [3], p_v [3];
  always #5 clk = ~clk;
  my_serial_adder #(.WIDTH(32), .DIGIT(4)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0]));
  my_serial_adder #(.WIDTH(32), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1]));
  my_serial_adder #(.WIDTH(32), .DIGIT(32)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2]));
  function automatic int nd(input int i);
    return i == 0 ? 8 : i == 1 ? 32 : 1;
  endfunction
  task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", n, i, act, exp, $time);
    end
  endtask
  // model: an op accepted while idle completes nd(i) edges later with plain 33-bit arithmetic
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rem[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_c[i] = 0; m_v[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit take;
        logic [31:0] bb;
        take = (rem[i] == 0) && start;
        m_done[i] = 0;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            m_done[i] = 1; m_sum[i] = p_sum[i]; m_c[i] = p_c[i]; m_v[i] = p_v[i];
          end
        end
        if (take) begin
          bb = sub ? ~b : b;
          rem[i] = nd(i);
          {p_c[i], p_sum[i]} = {1'b0, a} + {1'b0, bb} + 33'(sub);
          p_v[i] = (a[31] == bb[31]) && (p_sum[i][31] != a[31]);
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, 32'(busy[i]), 32'(rem[i] > 0));
      chk("done", i, 32'(done[i]), 32'(m_done[i]));
      chk("sum", i, sum[i], m_sum[i]);
      chk("c_out", i, 32'(c_out[i]), 32'(m_c[i]));
      chk("ovf", i, 32'(ovf[i]), 32'(m_v[i]));
    end
  end
  task automatic step();
    @(posedge clk) #1;
  endtask
  task automatic wait_idle();
    for (int g = 0; g < 100 && busy != 3'b000; g++) step();
    chk("idle", 0, 32'(busy), 32'd0);
  endtask
  task automatic op(input logic [31:0] x, input logic [31:0] y, input bit s,
                    input logic [31:0] es, input bit ec, input bit ev);
    int lat [3];
    wait_idle();
    a = x; b = y; sub = s; start = 1'b1;
    step();
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    lat = '{-1, -1, -1};
    for (int t = 1; t <= 40; t++) begin
      step();
      for (int i = 0; i < 3; i++) if (done[i] && lat[i] < 0) begin
        lat[i] = t;
        chk("op_sum", i, sum[i], es);
        chk("op_c", i, 32'(c_out[i]), 32'(ec));
        chk("op_ovf", i, 32'(ovf[i]), 32'(ev));
      end
    end
    for (int i = 0; i < 3; i++) chk("op_latency", i, 32'(lat[i]), 32'(nd(i)));
  endtask
  initial begin
    int t;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < 3; i++) begin
        chk("rst_busy", i, 32'(busy[i]), 32'd0);
        chk("rst_done", i, 32'(done[i]), 32'd0);
        chk("rst_sum", i, sum[i], 32'd0);
        chk("rst_flags", i, 32'({c_out[i], ovf[i]}), 32'd0);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("idle_after_rst", 0, 32'(busy), 32'd0);
    end
    op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    op(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op(32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op(32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_idle();
    a = 32'h5; b = 32'h7; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    a = 32'h1; b = 32'h1; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 20 && !done[0]; g++) step();
    chk("mid_done", 0, 32'(done[0]), 32'd1);
    chk("mid_sum", 0, sum[0], 32'hFFFF_FFFE);
    chk("mid_c", 0, 32'(c_out[0]), 32'd0);
    wait_idle();
    a = 32'h8000_0000; b = 32'h1; sub = 1'b1; start = 1'b1;
    step();
    for (int g = 0; g < 20 && !done[0]; g++) step();
    chk("b2b_first_done", 0, 32'(done[0]), 32'd1);
    chk("b2b_first_sum", 0, sum[0], 32'h7FFF_FFFF);
    chk("b2b_first_flags", 0, 32'({c_out[0], ovf[0]}), 32'b11);
    a = 32'hFFFF_FFFF; b = 32'h1; sub = 1'b0;
    step();
    start = 1'b0;
    t = 1;
    while (!done[0] && t < 20) begin
      step();
      t++;
    end
    chk("b2b_latency", 0, 32'(t), 32'd9);
    chk("b2b_sum", 0, sum[0], 32'h0);
    chk("b2b_flags", 0, 32'({c_out[0], ovf[0]}), 32'b10);
    wait_idle();
    a = 32'h7FFF_FFFF; b = 32'h1; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(busy), 32'd0);
    chk("abort_sum", 0, sum[0], 32'h0);
    chk("abort_flags", 0, 32'({c_out[0], ovf[0]}), 32'd0);
    a = $urandom; b = $urandom; start = 1'b1;
    step();
    step();
    start = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("abort_no_done", 0, 32'(done), 32'd0);
    end
    op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
